// File: rtl/grid_arbiter_if.sv
// grid_arbiter_if: requester, result and grid-RAM signals of grid_arbiter.
//
// Handshake: requester i raises req[i] together with op/addr/wdata and holds
// them until it sees done[i]. The arbiter answers with gnt[i], which stays high
// for the whole service, then a one-cycle done[i] that carries rdata/claimed.
// The grid RAM answers mem_read with mem_dout one cycle later; mem_write
// commits mem_din to mem_addr at the clock edge that samples it.
interface grid_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req;
    logic [2*NREQ-1:0]      op;
    logic [ADDR_W*NREQ-1:0] addr;
    logic [DATA_W*NREQ-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   claimed;
    logic                   mem_read;
    logic                   mem_write;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_din;
    logic [DATA_W-1:0]      mem_dout;
    // Arbiter FSM state: 0 IDLE, 1 RD, 2 CHK, 3 WR, 4 DONE
    logic [2:0]             dbg_state;

    modport slave (
        input  req, op, addr, wdata, mem_dout,
        output gnt, done, rdata, claimed,
        output mem_read, mem_write, mem_addr, mem_din, dbg_state
    );

    modport master (
        output req, op, addr, wdata, mem_dout,
        input  gnt, done, rdata, claimed,
        input  mem_read, mem_write, mem_addr, mem_din, dbg_state
    );
endinterface

// File: rtl/grid_arbiter.sv
// grid_arbiter: round-robin arbiter that serialises read / write / claim
// transactions from NREQ requesters onto one grid RAM. A claim is an atomic
// read-test-write: the cell is taken only if it currently holds all ones.
//
// Optional feature: define GRID_ARB_BOUNDS_EN to reject addresses
// >= GRID_CELLS without touching memory (rdata = all ones, claimed = 0).
//
// Timing from the acceptance edge: write done +2, read done +3, claim done +4,
// rejected address done +2. done rises on the edge that leaves DONE.
module grid_arbiter #(
    parameter int NREQ       = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int GRID_CELLS = 144
) (
    input  logic          clk,
    input  logic          reset,
    grid_arbiter_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_CLAIM = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_wdata;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_claimed;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_din;

    logic                w_any;
    logic [IDX_W-1:0]    w_sel;
    logic [IDX_W-1:0]    w_cand;
    logic [1:0]          w_sel_op;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_oob;

    // Round-robin pick: scan from r_rr_ptr upward; the descending loop lets
    // the nearest candidate after the pointer overwrite farther ones.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + k) % NREQ);
            if (bus.req[w_cand]) begin
                w_any = 1'b1;
                w_sel = w_cand;
            end
        end
    end

    // Fetch the selected requester's opcode, address and value.
    always_comb begin
        w_sel_op    = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_sel == IDX_W'(k)) begin
                w_sel_op    = bus.op[2*k +: 2];
                w_sel_addr  = bus.addr[ADDR_W*k +: ADDR_W];
                w_sel_wdata = bus.wdata[DATA_W*k +: DATA_W];
            end
        end
    end

`ifdef GRID_ARB_BOUNDS_EN
    assign w_oob = (w_sel_addr >= ADDR_W'(GRID_CELLS));
`else
    // Without the bounds option every address goes to the RAM as given.
    logic w_unused_cells;
    assign w_unused_cells = (GRID_CELLS != 0);
    assign w_oob          = 1'b0;
`endif

    // Arbiter FSM; every output is a register updated here. The WR state is
    // the write slot of a write or claim; it also serves as the dead cycle
    // for an occupied claim or a rejected address so latencies stay fixed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_op        <= '0;
            r_wdata     <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_claimed   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= NREQ'(1) << w_sel;
                        r_op       <= w_sel_op;
                        r_wdata    <= w_sel_wdata;
                        r_claimed  <= 1'b0;
                        r_mem_addr <= w_sel_addr;
                        r_rr_ptr   <= (w_sel == IDX_W'(NREQ - 1)) ? '0 : w_sel + 1'b1;
                        if (w_oob) begin
                            r_rdata <= '1;
                            r_state <= S_WR;
                        end else if (w_sel_op == OP_WRITE) begin
                            r_mem_write <= 1'b1;
                            r_mem_din   <= w_sel_wdata;
                            r_state     <= S_WR;
                        end else begin
                            // read, claim and the reserved opcode all start with a read
                            r_mem_read <= 1'b1;
                            r_state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_mem_read <= 1'b0;
                    r_state    <= S_CHK;
                end
                S_CHK: begin
                    // mem_dout holds the cell this cycle
                    r_rdata <= bus.mem_dout;
                    if (r_op == OP_CLAIM) begin
                        if (bus.mem_dout == '1) begin
                            r_mem_write <= 1'b1;
                            r_mem_din   <= r_wdata;
                            r_claimed   <= 1'b1;
                        end
                        r_state <= S_WR;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_WR: begin
                    r_mem_write <= 1'b0;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= r_gnt;
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.rdata     = r_rdata;
    assign bus.claimed   = r_claimed;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_din   = r_mem_din;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_grid_arbiter.sv
// tb_grid_arbiter: directed bench for grid_arbiter with a small grid RAM.
// Builds with or without GRID_ARB_BOUNDS_EN.
module tb_grid_arbiter;
    logic clk = 1'b0;
    logic reset;

    grid_arbiter_if #(.NREQ(4), .ADDR_W(32), .DATA_W(32)) bus ();

    grid_arbiter #(
        .NREQ(4), .ADDR_W(32), .DATA_W(32), .GRID_CELLS(144)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Grid RAM: registered read data, preloaded while reset is held
    logic [31:0] mem [0:255];
    logic [31:0] mem_dout_r;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[10]    <= '1;
            mem[20]    <= '1;
            mem[30]    <= '1;
            mem[200]   <= 32'h0000_00C8;
            mem_dout_r <= '0;
        end else begin
            if (bus.mem_read)  mem_dout_r <= mem[bus.mem_addr[7:0]];
            if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_din;
        end
    end
    assign bus.mem_dout = mem_dout_r;

    // Bus monitor, sampled on the falling edge
    int          cyc = 0;
    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, ovl_cnt = 0, done_cnt = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0, last_raddr = '0;
    logic [3:0]  prev_gnt = '0;
    logic [1:0]  got_q[$];
    int          stamp_q[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_write) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= bus.mem_addr;
            last_wdata <= bus.mem_din;
        end
        if (bus.mem_read) begin
            rd_cnt     <= rd_cnt + 1;
            last_raddr <= bus.mem_addr;
        end
        if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
        if ($countones(bus.gnt) > 1) ovl_cnt <= ovl_cnt + 1;
        if (bus.done != '0) done_cnt <= done_cnt + 1;
        for (int i = 0; i < 4; i++) begin
            if (bus.gnt[i] && !prev_gnt[i]) begin
                got_q.push_back(2'(i));
                stamp_q.push_back(cyc);
            end
        end
        prev_gnt <= bus.gnt;
    end

    // Scoreboard
    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic issue(input int idx, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] d);
        bus.op[2*idx +: 2]     = o;
        bus.addr[32*idx +: 32]  = a;
        bus.wdata[32*idx +: 32] = d;
        bus.req[idx]           = 1'b1;
    endtask

    // lat counts posedges since acceptance (first falling edge after it = 0);
    // 99 means done never came. req is dropped once done is seen.
    task automatic wait_done(input int idx, output int lat, output logic [31:0] rd,
                             output logic cl, output logic [3:0] dn);
        bit found = 1'b0;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            lat++;
            if (bus.done[idx]) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) lat = 99;
        rd = bus.rdata;
        cl = bus.claimed;
        dn = bus.done;
        bus.req[idx] = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.gnt == '0 && bus.done == '0 && bus.dbg_state == 3'd0) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1);
        @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        int          lat;
        logic [31:0] rd;
        logic        cl;
        logic [3:0]  dn;
        int          wr0, rd0, dn0;

        reset     = 1'b1;
        bus.req   = '0;
        bus.op    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_claimed", bus.claimed, 0);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_din", bus.mem_din, 0);
        check("rst_state", bus.dbg_state, 0);
        reset = 1'b0;
        @(negedge clk);

        // Write: cell 5 <= 7, done at +2
        wr0 = wr_cnt;
        issue(0, 2'd1, 32'd5, 32'd7);
        wait_done(0, lat, rd, cl, dn);
        check("wr_lat", lat, 2);
        check("wr_done_vec", dn, 4'b0001);
        check("wr_gnt_clear", bus.gnt, 0);
        @(negedge clk);
        check("wr_count", wr_cnt - wr0, 1);
        check("wr_addr", last_waddr, 5);
        check("wr_data", last_wdata, 7);
        check("wr_cell", mem[5], 7);

        // Claim on free cell 10 by requester 1
        wr0 = wr_cnt;
        issue(1, 2'd2, 32'd10, 32'd3);
        wait_done(1, lat, rd, cl, dn);
        check("clf_lat", lat, 4);
        check("clf_claimed", cl, 1);
        check("clf_rdata", rd, 32'hFFFF_FFFF);
        check("clf_done_vec", dn, 4'b0010);
        @(negedge clk);
        check("clf_wr_count", wr_cnt - wr0, 1);
        check("clf_wr_addr", last_waddr, 10);
        check("clf_cell", mem[10], 3);

        // Claim on occupied cell 10 by requester 2
        wr0 = wr_cnt;
        issue(2, 2'd2, 32'd10, 32'd4);
        wait_done(2, lat, rd, cl, dn);
        check("clo_lat", lat, 4);
        check("clo_claimed", cl, 0);
        check("clo_rdata", rd, 3);
        @(negedge clk);
        check("clo_wr_count", wr_cnt - wr0, 0);
        check("clo_cell", mem[10], 3);

        // Plain read of cell 5 by requester 3, done at +3
        rd0 = rd_cnt;
        issue(3, 2'd0, 32'd5, 32'd0);
        wait_done(3, lat, rd, cl, dn);
        check("rd_lat", lat, 3);
        check("rd_rdata", rd, 7);
        check("rd_done_vec", dn, 4'b1000);
        @(negedge clk);
        check("rd_count", rd_cnt - rd0, 1);

        // Reserved opcode 3 behaves as a read
        wr0 = wr_cnt;
        issue(0, 2'd3, 32'd10, 32'd9);
        wait_done(0, lat, rd, cl, dn);
        check("op3_lat", lat, 3);
        check("op3_rdata", rd, 3);
        @(negedge clk);
        check("op3_no_write", wr_cnt - wr0, 0);

        // Requester drops req and changes addr after acceptance
        issue(1, 2'd0, 32'd5, 32'd0);
        @(negedge clk);
        check("drop_gnt", bus.gnt, 4'b0010);
        bus.req[1]        = 1'b0;
        bus.addr[32 +: 32] = 32'd10;
        wait_done(1, lat, rd, cl, dn);
        check("drop_lat", lat, 2);
        check("drop_rdata", rd, 7);
        @(negedge clk);

`ifdef GRID_ARB_BOUNDS_EN
        // Out-of-range claim: no memory access, done at +2
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(2, 2'd2, 32'd200, 32'd9);
        wait_done(2, lat, rd, cl, dn);
        check("oob_lat", lat, 2);
        check("oob_claimed", cl, 0);
        check("oob_rdata", rd, 32'hFFFF_FFFF);
        @(negedge clk);
        check("oob_no_read", rd_cnt - rd0, 0);
        check("oob_no_write", wr_cnt - wr0, 0);
`else
        // Large address passes through unchanged (RAM aliases it to cell 200)
        rd0 = rd_cnt;
        issue(2, 2'd0, 32'h0001_00C8, 32'd0);
        wait_done(2, lat, rd, cl, dn);
        check("pass_lat", lat, 3);
        check("pass_rdata", rd, 32'h0000_00C8);
        @(negedge clk);
        check("pass_addr", last_raddr, 32'h0001_00C8);
        check("pass_count", rd_cnt - rd0, 1);
`endif

        // Reset while a claim sits in CHK
        wr0 = wr_cnt;
        dn0 = done_cnt;
        issue(2, 2'd2, 32'd30, 32'd5);
        @(negedge clk);
        check("rchk_state_rd", bus.dbg_state, 1);
        @(negedge clk);
        check("rchk_state_chk", bus.dbg_state, 2);
        reset = 1'b1;
        #1;
        check("rchk_gnt", bus.gnt, 0);
        check("rchk_state", bus.dbg_state, 0);
        check("rchk_mem_write", bus.mem_write, 0);
        check("rchk_mem_read", bus.mem_read, 0);
        check("rchk_mem_addr", bus.mem_addr, 0);
        check("rchk_mem_din", bus.mem_din, 0);
        check("rchk_rdata", bus.rdata, 0);
        check("rchk_claimed", bus.claimed, 0);
        bus.req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rchk_no_write", wr_cnt - wr0, 0);
        check("rchk_no_done", done_cnt - dn0, 0);

        // Fairness: four reads held high from pointer 0
        got_q.delete();
        stamp_q.delete();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) issue(i, 2'd0, 32'd5, 32'd0);
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (got_q.size() >= 5) break;
        end
        bus.req = '0;
        check("fair_count", got_q.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fair_order%0d", i), got_q[i], exp_q[i]);
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fair_gap%0d", i), stamp_q[i+1] - stamp_q[i], 4);
        end
        wait_idle("fair_idle");

        // Single requester held high: granted back to back
        got_q.delete();
        stamp_q.delete();
        issue(0, 2'd0, 32'd5, 32'd0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (got_q.size() >= 2) break;
        end
        bus.req = '0;
        check("b2b_first", got_q[0], 0);
        check("b2b_second", got_q[1], 0);
        check("b2b_gap", stamp_q[1] - stamp_q[0], 4);
        wait_idle("b2b_idle");

        // Contention on free cell 20 from pointer 0
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(0, 2'd2, 32'd20, 32'd11);
        issue(1, 2'd2, 32'd20, 32'd12);
        wait_done(0, lat, rd, cl, dn);
        check("cont0_lat", lat, 4);
        check("cont0_claimed", cl, 1);
        check("cont0_rdata", rd, 32'hFFFF_FFFF);
        wait_done(1, lat, rd, cl, dn);
        check("cont1_lat", lat, 4);
        check("cont1_claimed", cl, 0);
        check("cont1_rdata", rd, 11);
        @(negedge clk);
        check("cont_cell", mem[20], 11);

        // Whole-run properties
        check("never_rd_and_wr", both_cnt, 0);
        check("never_gnt_overlap", ovl_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grid_arbiter.md
GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 SHALL have parameters: NREQ, default 4, number of requesters; ADDR_W, default 32, grid address width; DATA_W, default 32, cell width; GRID_CELLS, default 144, number of valid cells.
REQ-002 SHALL have port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  in  NREQ  per-requester request level, held until done.
REQ-005 SHALL have port: op  in  2*NREQ  per-requester opcode: 0 read, 1 write, 2 claim, 3 reserved (treated as read).
REQ-006 SHALL have port: addr  in  ADDR_W*NREQ  per-requester cell address.
REQ-007 SHALL have port: wdata  in  DATA_W*NREQ  per-requester write/claim value (node id).
REQ-008 SHALL have port: gnt  out  NREQ  one-hot, high for the whole service of the winner.
REQ-009 SHALL have port: done  out  NREQ  one-cycle completion pulse to the winner.
REQ-010 SHALL have port: rdata  out  DATA_W  cell value read; valid with done.
REQ-011 SHALL have port: claimed  out  1  claim succeeded; valid with done.
REQ-012 SHALL have ports: mem_read  out  1; mem_write  out  1; mem_addr  out  ADDR_W; mem_din  out  DATA_W; mem_dout  in  DATA_W. Grid RAM: mem_dout is valid in the cycle after mem_read is sampled.

Function
REQ-013 SHALL be a registered FSM with states IDLE, RD, CHK, WR, DONE; all outputs registered.
REQ-014 In IDLE with any req high, SHALL select the winner round-robin, starting at the index after the last winner; the post-reset start index is 0.
REQ-015 At acceptance, SHALL latch the winner's op, addr and wdata and set the gnt bit. Later changes to that requester's inputs SHALL be ignored until done.
REQ-016 Write: SHALL drive mem_write=1, mem_addr, mem_din=wdata for one cycle, then go to DONE; done SHALL pulse 2 cycles after acceptance.
REQ-017 Read: SHALL drive mem_read=1, go to RD, capture mem_dout into rdata, then go to DONE; done SHALL pulse 3 cycles after acceptance.
REQ-018 Claim: SHALL perform the read as in REQ-017, then go to CHK.
  - Captured value == -1 (all ones): go to WR, write wdata to the same address, claimed=1.
  - Otherwise: claimed=0 and no write.
  - done SHALL pulse 4 cycles after acceptance in both cases; rdata SHALL carry the pre-claim value.
REQ-019 The read-test-write of a claim SHALL be atomic: no other requester's memory access SHALL occur between its read and its write.
REQ-020 In DONE, SHALL pulse done[winner], clear gnt, and return to IDLE. A new acceptance SHALL occur no earlier than the next cycle.
REQ-021 SHALL never assert mem_read and mem_write in the same cycle.
REQ-022 A requester that drops req after acceptance SHALL still be fully serviced.
REQ-023 With a single requester continuously requesting, SHALL grant it back to back.

Reset
REQ-024 Reset SHALL force immediately:
  - IDLE state;
  - gnt=0, done=0, rdata=0, claimed=0;
  - mem_read=0, mem_write=0, mem_addr=0, mem_din=0;
  - round-robin pointer to 0.
REQ-025 Reset during a claim SHALL abort it with no further memory write; done SHALL not pulse.

Configuration
REQ-026 Macro GRID_ARB_BOUNDS_EN: when defined, a latched addr >= GRID_CELLS SHALL skip all memory access and go straight to DONE (done 2 cycles after acceptance), with rdata=-1 and claimed=0. When undefined, no range check SHALL be made and the address SHALL pass through unchanged.

Verification
REQ-027 Write: req[0], op=1, addr=5, wdata=7 -> mem_write at addr 5 with 7; done[0] pulses 2 cycles after acceptance.
REQ-028 Claim on a free cell: cell 10 = -1; req[1] claim addr=10, wdata=3 -> claimed=1, rdata=-1, cell 10 = 3, done at +4.
REQ-029 Claim on an occupied cell: repeat REQ-028 with req[2], wdata=4 -> claimed=0, rdata=3, no mem_write.
REQ-030 Fairness: req=4'b1111, all reads held high -> grant order 0,1,2,3,0; no gnt overlap.
REQ-031 Contention: req[0] and req[1] both claim cell 20 (free) in the same cycle -> exactly one claimed=1 (index 0 after reset), the other claimed=0.
REQ-032 Reset in CHK -> no mem_write, outputs 0 immediately. With GRID_ARB_BOUNDS_EN, a claim to addr=200 -> claimed=0, rdata=-1, no memory access.
